// File: rtl/sortvis_pkg.sv
// Shared definitions for the sorting visualiser front end: button indices,
// repeat FSM encoding and a counter-width helper.
package sortvis_pkg;

  localparam int BTN_C = 0;
  localparam int BTN_R = 1;
  localparam int BTN_L = 2;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_HOLD       = 2'd1,
    ST_REPEAT     = 2'd2,
    ST_HELD_NOREP = 2'd3
  } rep_state_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, stability counter, debounced level
// and registered press/release pulses. rise/fall flag next cycle's edges.
module debounce_channel
  import sortvis_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // left one unassigned would infer a latch.
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) stable_d = sync2_q;
      else                                  cnt_d    = cnt_q + 1'b1;
    end
    press_d = stable_d & ~stable_q;
    rel_d   = ~stable_d & stable_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values;
    // the synchroniser chain depends on it.
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
    end
  end

  assign level = stable_q;
  assign press = press_q;
  assign rel   = rel_q;
  assign rise  = press_d;
  assign fall  = rel_d;

endmodule

// File: rtl/button_conditioner.sv
// Debounced level, press/release pulses and auto-repeat fire pulses for the
// push buttons; one debounce channel and one repeat FSM per button.
module button_conditioner
  import sortvis_pkg::*;
#(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_fire
);

  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = cnt_width(REP_MAX);

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    logic             rise, fall;
    rep_state_e       state_q, state_d;
    logic [REP_W-1:0] cnt_q, cnt_d;
    logic             fire_q, fire_d;

    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .btn_raw(btn_in[g]),
      .level  (btn_level[g]),
      .press  (btn_press[g]),
      .rel    (btn_release[g]),
      .rise   (rise),
      .fall   (fall)
    );

    // Release beats everything, then a dropped enable, then the timed fire.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fire_d  = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (rise) begin
            fire_d  = 1'b1;
            state_d = repeat_en[g] ? ST_HOLD : ST_HELD_NOREP;
          end
        end
        ST_HOLD: begin
          if (fall) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (!repeat_en[g]) begin
            state_d = ST_HELD_NOREP;
            cnt_d   = '0;
          end else if (cnt_q == REP_W'(REPEAT_DELAY - 1)) begin
            fire_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_REPEAT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (fall) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (!repeat_en[g]) begin
            state_d = ST_HELD_NOREP;
            cnt_d   = '0;
          end else if (cnt_q == REP_W'(REPEAT_PERIOD - 1)) begin
            fire_d = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_HELD_NOREP: begin
          cnt_d = '0;
          if (fall) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        fire_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        fire_q  <= fire_d;
      end
    end

    assign btn_fire[g] = fire_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with short debounce/repeat timing.
module tb_button_conditioner;
  import sortvis_pkg::*;

  localparam int DB  = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
  localparam int LAT = DB + 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] btn_in, repeat_en;
  logic [2:0] btn_level, btn_press, btn_release, btn_fire;

  button_conditioner #(
    .N_BTN(3), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .repeat_en  (repeat_en),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_fire   (btn_fire)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         cyc;
    logic [2:0] level, press, rel, fire;
  } exp_t;

  typedef struct {
    logic       rst;
    logic [2:0] btn, ren;
    logic [2:0] level, press, rel, fire;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[47];

  task automatic check(input string name, input int at, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, at, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [2:0] l, input logic [2:0] p,
                      input logic [2:0] r, input logic [2:0] f);
    exp_t e;
    e.cyc = c; e.level = l; e.press = p; e.rel = r; e.fire = f;
    sb.push_back(e);
  endtask

  function automatic logic [2:0] bit_at(input int ch, input bit on);
    logic [2:0] r;
    r     = '0;
    r[ch] = on;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Outputs are compared mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      mon_e = sb.pop_front();
      check("level",   cyc, btn_level,   mon_e.level);
      check("press",   cyc, btn_press,   mon_e.press);
      check("release", cyc, btn_release, mon_e.rel);
      check("fire",    cyc, btn_fire,    mon_e.fire);
    end
  end

  // Auto-repeat on btnL: fires at press+0, +10, +13 ... until the debounced release.
  task automatic sc_repeat();
    int p;
    bit f;
    p = cyc + 1 + LAT;
    btn_in    = bit_at(BTN_L, 1);
    repeat_en = bit_at(BTN_L, 1);
    for (int k = -LAT; k < 40; k++) begin
      f = (k == 0) || (k >= RD && k < 37 && ((k - RD) % RP) == 0);
      push(p + k, bit_at(BTN_L, k >= 0 && k < 37), bit_at(BTN_L, k == 0),
           bit_at(BTN_L, k == 37), bit_at(BTN_L, f));
    end
    tick(p + 30 - cyc);
    btn_in = '0;
    tick(p + 40 - cyc);
    repeat_en = '0;
  endtask

  // No repeat on btnC; enabling repeat mid-hold must not start it.
  task automatic sc_norep();
    int p;
    p = cyc + 1 + LAT;
    btn_in    = bit_at(BTN_C, 1);
    repeat_en = '0;
    for (int k = -LAT; k < 50; k++)
      push(p + k, bit_at(BTN_C, k >= 0 && k < 47), bit_at(BTN_C, k == 0),
           bit_at(BTN_C, k == 47), bit_at(BTN_C, k == 0));
    tick(p + 15 - cyc);
    repeat_en = bit_at(BTN_C, 1);
    tick(p + 40 - cyc);
    btn_in = '0;
    tick(p + 50 - cyc);
    repeat_en = '0;
  endtask

  task automatic sc_simul();
    int p;
    p = cyc + 1 + LAT;
    btn_in = 3'b111;
    for (int k = -LAT; k < 10; k++)
      push(p + k, (k >= 0 && k < 8) ? 3'b111 : 3'b000, (k == 0) ? 3'b111 : 3'b000,
           (k == 8) ? 3'b111 : 3'b000, (k == 0) ? 3'b111 : 3'b000);
    tick(p + 1 - cyc);
    btn_in = '0;
    tick(p + 10 - cyc);
  endtask

  // Reset in REPEAT with btnR held: outputs clear, then a fresh press and a
  // repeat schedule restarting from the new press.
  task automatic sc_reset();
    int p, q;
    bit f, l;
    p = cyc + 1 + LAT;
    q = 23;
    btn_in    = bit_at(BTN_R, 1);
    repeat_en = bit_at(BTN_R, 1);
    for (int k = -LAT; k < 46; k++) begin
      if (k < 15) begin
        l = (k >= 0);
        f = (k == 0) || (k == RD) || (k == RD + RP);
      end else begin
        l = (k >= q && k < 43);
        f = (k == q) || (k >= q + RD && k < 43 && ((k - q - RD) % RP) == 0);
      end
      push(p + k, bit_at(BTN_R, l), bit_at(BTN_R, k == 0 || k == q),
           bit_at(BTN_R, k == 43), bit_at(BTN_R, f));
    end
    tick(p + 14 - cyc);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(p + 36 - cyc);
    btn_in = '0;
    tick(p + 46 - cyc);
    repeat_en = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    bit b0;
    int j;
    // Clean press and release on btnR, then a bounced press on btnC.
    for (int i = 0; i < 17; i++) begin
      vecs[i].rst   = 1'b0;
      vecs[i].ren   = '0;
      vecs[i].btn   = bit_at(BTN_R, i < 9);
      vecs[i].level = bit_at(BTN_R, i >= LAT && i < 9 + LAT);
      vecs[i].press = bit_at(BTN_R, i == LAT);
      vecs[i].fire  = bit_at(BTN_R, i == LAT);
      vecs[i].rel   = bit_at(BTN_R, i == 9 + LAT);
    end
    for (int i = 17; i < 47; i++) begin
      j  = i - 17;
      b0 = (j <= 2) || (j == 4) || (j == 5) || (j >= 12 && j <= 20);
      vecs[i].rst   = 1'b0;
      vecs[i].ren   = '0;
      vecs[i].btn   = bit_at(BTN_C, b0);
      vecs[i].level = bit_at(BTN_C, j >= 12 + LAT && j < 21 + LAT);
      vecs[i].press = bit_at(BTN_C, j == 12 + LAT);
      vecs[i].fire  = bit_at(BTN_C, j == 12 + LAT);
      vecs[i].rel   = bit_at(BTN_C, j == 21 + LAT);
    end

    reset     = 1'b1;
    btn_in    = '0;
    repeat_en = '0;
    tick(1);
    for (int i = 1; i <= 3; i++) push(cyc + i, '0, '0, '0, '0);
    tick(3);
    reset = 1'b0;

    foreach (vecs[i]) begin
      reset     = vecs[i].rst;
      btn_in    = vecs[i].btn;
      repeat_en = vecs[i].ren;
      push(cyc + 1, vecs[i].level, vecs[i].press, vecs[i].rel, vecs[i].fire);
      tick(1);
    end

    tick(3);
    sc_repeat();
    tick(3);
    sc_norep();
    tick(3);
    sc_simul();
    tick(3);
    sc_reset();
    tick(3);

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drained: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
